// File: rtl/gpio_bus_master.sv
// gpio_bus_master: turns 4-bit command nibbles into single register-bus accesses.
// A frame is OP, ADDR, then DHI and DLO for writes. OP 0x1 is a write and 0x2 is a read.
// Read data, and optionally the write echo, goes back through the rsp_* handshake.
// A bus access that waits TIMEOUT_CYC cycles without bus_ready is abandoned.
// Optional feature macro GPIO_BUS_AUTOINC_EN: OP 0x9 writes and OP 0xA reads at an
// internal address pointer, and these frames carry no ADDR nibble.
module gpio_bus_master #(
   parameter int unsigned TIMEOUT_CYC = 16,
   parameter bit          WR_ACK      = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] nib_in,
   input  logic       nib_valid,
   output logic       nib_ready,
   output logic [3:0] bus_addr,
   output logic [7:0] bus_wdata,
   output logic       bus_we,
   output logic       bus_re,
   input  logic [7:0] bus_rdata,
   input  logic       bus_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_valid,
   output logic       rsp_err,
   input  logic       rsp_ready,
   output logic       busy,
   output logic       cmd_err
);

   // The last strobe cycle has the count at TIMEOUT_CYC-1.
   localparam logic [7:0] TermCnt = 8'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      StIdle,
      StGetAddr,
      StGetDhi,
      StGetDlo,
      StBusWr,
      StBusRd,
      StResp
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] rsp_data_q, rsp_data_d;
   logic       rsp_err_q, rsp_err_d;
   logic       cmd_err_q, cmd_err_d;
   logic [7:0] cnt_q, cnt_d;
   logic       wr_q, wr_d;
`ifdef GPIO_BUS_AUTOINC_EN
   logic [3:0] ptr_q, ptr_d;
`endif

   logic nib_fire;
   assign nib_fire = nib_valid & nib_ready;

   // Outputs decode straight from registered state, so reset drops the strobes at once.
   assign nib_ready = (state_q == StIdle) || (state_q == StGetAddr) ||
                      (state_q == StGetDhi) || (state_q == StGetDlo);
   assign busy      = (state_q != StIdle);
   assign bus_we    = (state_q == StBusWr);
   assign bus_re    = (state_q == StBusRd);
   assign rsp_valid = (state_q == StResp);
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign cmd_err   = cmd_err_q;

   // Next-state: frame assembly, bus access with timeout, response handshake.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      cmd_err_d  = 1'b0;
      cnt_d      = cnt_q;
      wr_d       = wr_q;
`ifdef GPIO_BUS_AUTOINC_EN
      ptr_d      = ptr_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (nib_fire) begin
               case (nib_in)
                  4'h1: begin
                     wr_d    = 1'b1;
                     state_d = StGetAddr;
                  end
                  4'h2: begin
                     wr_d    = 1'b0;
                     state_d = StGetAddr;
                  end
`ifdef GPIO_BUS_AUTOINC_EN
                  4'h9: begin
                     wr_d    = 1'b1;
                     addr_d  = ptr_q;
                     state_d = StGetDhi;
                  end
                  4'hA: begin
                     wr_d    = 1'b0;
                     addr_d  = ptr_q;
                     cnt_d   = 8'd0;
                     state_d = StBusRd;
                  end
`endif
                  default: cmd_err_d = 1'b1;
               endcase
            end
         end
         StGetAddr: begin
            if (nib_fire) begin
               addr_d  = nib_in;
               cnt_d   = 8'd0;
               state_d = wr_q ? StGetDhi : StBusRd;
            end
         end
         StGetDhi: begin
            if (nib_fire) begin
               wdata_d[7:4] = nib_in;
               state_d      = StGetDlo;
            end
         end
         StGetDlo: begin
            if (nib_fire) begin
               wdata_d[3:0] = nib_in;
               cnt_d        = 8'd0;
               state_d      = StBusWr;
            end
         end
         StBusWr, StBusRd: begin
            // bus_ready wins over the terminal count.
            if (bus_ready || (cnt_q == TermCnt)) begin
`ifdef GPIO_BUS_AUTOINC_EN
               ptr_d = addr_q + 4'd1;
`endif
               if (state_q == StBusRd || WR_ACK) begin
                  state_d    = StResp;
                  rsp_err_d  = ~bus_ready;
                  rsp_data_d = !bus_ready ? 8'hFF :
                               (state_q == StBusRd) ? bus_rdata : wdata_q;
               end else begin
                  state_d   = StIdle;
                  cmd_err_d = ~bus_ready;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StResp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset abandons any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         addr_q     <= 4'd0;
         wdata_q    <= 8'd0;
         rsp_data_q <= 8'd0;
         rsp_err_q  <= 1'b0;
         cmd_err_q  <= 1'b0;
         cnt_q      <= 8'd0;
         wr_q       <= 1'b0;
`ifdef GPIO_BUS_AUTOINC_EN
         ptr_q      <= 4'd0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         cmd_err_q  <= cmd_err_d;
         cnt_q      <= cnt_d;
         wr_q       <= wr_d;
`ifdef GPIO_BUS_AUTOINC_EN
         ptr_q      <= ptr_d;
`endif
      end
   end

endmodule

// File: tb/tb_gpio_bus_master.sv
// Bench for gpio_bus_master: directed cases followed by random transactions.
// Expected results come from a model register file, a model address pointer and the
// rule that the strobe lasts min(latency+1, TMO) cycles.
module tb_gpio_bus_master;

   localparam int TMO    = 16;
   localparam bit WR_ACK = 1'b0;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] nib_in;
   logic       nib_valid;
   logic       nib_ready;
   logic [3:0] bus_addr;
   logic [7:0] bus_wdata;
   logic       bus_we;
   logic       bus_re;
   logic [7:0] bus_rdata;
   logic       bus_ready;
   logic [7:0] rsp_data;
   logic       rsp_valid;
   logic       rsp_err;
   logic       rsp_ready;
   logic       busy;
   logic       cmd_err;

   int checks   = 0;
   int failures = 0;

   logic [7:0] mem [16];
   logic [3:0] ptr;

   gpio_bus_master #(
      .TIMEOUT_CYC(TMO),
      .WR_ACK     (WR_ACK)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .nib_in   (nib_in),
      .nib_valid(nib_valid),
      .nib_ready(nib_ready),
      .bus_addr (bus_addr),
      .bus_wdata(bus_wdata),
      .bus_we   (bus_we),
      .bus_re   (bus_re),
      .bus_rdata(bus_rdata),
      .bus_ready(bus_ready),
      .rsp_data (rsp_data),
      .rsp_valid(rsp_valid),
      .rsp_err  (rsp_err),
      .rsp_ready(rsp_ready),
      .busy     (busy),
      .cmd_err  (cmd_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals();
      chk("rst_nib_ready", nib_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_strobes", {bus_we, bus_re}, 0);
      chk("rst_rsp", {rsp_valid, rsp_err, cmd_err}, 0);
      chk("rst_addr", bus_addr, 0);
      chk("rst_wdata", bus_wdata, 0);
      chk("rst_rsp_data", rsp_data, 0);
   endtask

   task automatic send_nib(input logic [3:0] n);
      nib_in    = n;
      nib_valid = 1'b1;
      chk("nib_ready", nib_ready, 1);
      step();
      nib_valid = 1'b0;
   endtask

   // One full transaction; lat is the number of wait cycles before the responder answers.
   task automatic txn(input bit wr, input bit ai, input logic [3:0] a_in, input logic [7:0] d,
                      input int lat, input int hold);
      logic [3:0] a;
      logic [7:0] exp_rsp;
      int         n;
      bit         tmo;
      a = ai ? ptr : a_in;
      if (ai) begin
         send_nib(wr ? 4'h9 : 4'hA);
      end else begin
         send_nib(wr ? 4'h1 : 4'h2);
         send_nib(a);
      end
      if (wr) begin
         send_nib(d[7:4]);
         send_nib(d[3:0]);
      end
      tmo = (lat >= TMO);
      chk("strobe_kind", {bus_we, bus_re}, wr ? 2'b10 : 2'b01);
      chk("nib_ready_bus", nib_ready, 0);
      exp_rsp   = tmo ? 8'hFF : (wr ? d : mem[a]);
      bus_rdata = mem[a];
      n = 0;
      while ((bus_we || bus_re) && n < 300) begin
         chk("bus_addr", bus_addr, a);
         if (wr) chk("bus_wdata", bus_wdata, d);
         bus_ready = (n == lat);
         step();
         n++;
         bus_ready = 1'b0;
      end
      chk("strobe_len", n, tmo ? TMO : lat + 1);
      ptr = a + 4'd1;
      if (wr && !tmo) mem[a] = d;
      if (!wr || WR_ACK) begin
         chk("rsp_valid", rsp_valid, 1);
         chk("rsp_err", rsp_err, tmo);
         chk("rsp_data", rsp_data, exp_rsp);
         rsp_ready = 1'b0;
         for (int i = 0; i < hold; i++) begin
            step();
            chk("rsp_hold", {rsp_valid, rsp_err, rsp_data}, {1'b1, tmo, exp_rsp});
         end
         rsp_ready = 1'b1;
         step();
         rsp_ready = 1'b0;
         chk("rsp_cleared", rsp_valid, 0);
      end else begin
         chk("wr_no_rsp", rsp_valid, 0);
         chk("wr_tmo_cmd_err", cmd_err, tmo);
         if (tmo) begin
            step();
            chk("wr_tmo_cmd_err_off", cmd_err, 0);
         end
      end
      chk("back_idle", {busy, nib_ready}, 2'b01);
   endtask

   task automatic illegal(input logic [3:0] op);
      send_nib(op);
      chk("cmd_err_pulse", cmd_err, 1);
      chk("illegal_idle", {busy, nib_ready, bus_we, bus_re}, 4'b0100);
      step();
      chk("cmd_err_once", cmd_err, 0);
   endtask

   function automatic bit is_legal(input logic [3:0] op);
`ifdef GPIO_BUS_AUTOINC_EN
      return (op == 4'h1) || (op == 4'h2) || (op == 4'h9) || (op == 4'hA);
`else
      return (op == 4'h1) || (op == 4'h2);
`endif
   endfunction

   initial begin
      logic [3:0] op;
      int         r;
      rst       = 1'b1;
      nib_in    = 4'h0;
      nib_valid = 1'b0;
      bus_rdata = 8'h00;
      bus_ready = 1'b0;
      rsp_ready = 1'b0;
      ptr       = 4'h0;
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      #1;
      chk_reset_vals();
      step();
      step();
      rst = 1'b0;
      step();
      chk_reset_vals();

      // Zero-wait write: one strobe cycle, no response.
      txn(1'b1, 1'b0, 4'h3, 8'hA5, 0, 0);
      // Read with response held for three cycles.
      txn(1'b1, 1'b0, 4'h3, 8'h5C, 0, 0);
      txn(1'b0, 1'b0, 4'h3, 8'h00, 0, 3);
      // Read timeout, then the terminal-count success boundary.
      txn(1'b0, 1'b0, 4'h6, 8'h00, 1000, 1);
      txn(1'b0, 1'b0, 4'h7, 8'h00, TMO - 1, 0);
      // Write timeout pulses cmd_err.
      txn(1'b1, 1'b0, 4'hC, 8'h3E, TMO, 0);
      // Illegal opcode, then a normal read.
      illegal(4'h7);
      txn(1'b0, 1'b0, 4'h3, 8'h00, 2, 0);
      illegal(4'h9);
      illegal(4'hA);

      // Reset mid-write while the responder stalls.
      send_nib(4'h1);
      send_nib(4'h4);
      send_nib(4'hB);
      send_nib(4'hE);
      step();
      chk("wr_pending", bus_we, 1);
      rst = 1'b1;
      #1;
      chk_reset_vals();
      #1;
      rst = 1'b0;
      ptr = 4'h0;
      step();
      chk("post_rst_no_we", bus_we, 0);

      for (int t = 0; t < 40; t++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            op = 4'($urandom);
            while (is_legal(op)) op = 4'($urandom);
            illegal(op);
         end else begin
            txn(1'($urandom), 1'b0, 4'($urandom), 8'($urandom),
                (r == 1) ? $urandom_range(TMO - 2, TMO + 4) : $urandom_range(0, 4),
                $urandom_range(0, 2));
         end
      end

`ifdef GPIO_BUS_AUTOINC_EN
      txn(1'b1, 1'b0, 4'hF, 8'($urandom), 0, 0);
      chk("ptr_wrap", ptr, 4'h0);
      txn(1'b1, 1'b1, 4'h0, 8'h12, 0, 0);
      chk("ptr_after_ai_wr", ptr, 4'h1);
      txn(1'b0, 1'b1, 4'h0, 8'h00, 1, 0);
      txn(1'b0, 1'b0, 4'h0, 8'h00, 0, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
